// File: rtl/top.sv
// top: UART-fed N x N matrix multiplier returning C = A*B as 24-bit big-endian triples.
module top #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int MAX_N = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] b_sel,
  output logic       tx
);
  localparam int DW = $clog2(CLK_FREQ / 4800 + 1);
  localparam int AW = $clog2(MAX_N * MAX_N + 1);
  localparam logic [7:0] MAX_B = 8'(MAX_N);
  localparam logic [DW-1:0] D0 = DW'(CLK_FREQ / 4800);
  localparam logic [DW-1:0] D1 = DW'(CLK_FREQ / 9600);
  localparam logic [DW-1:0] D2 = DW'(CLK_FREQ / 57600);
  localparam logic [DW-1:0] D3 = DW'(CLK_FREQ / 115200);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, COMPUTE, SEND} st_t;
  rx_st_t rx_st_q;
  st_t st_q;
  logic rx_s1_q, rx_s2_q, rx_s3_q, rx_vld_q;
  logic [DW-1:0] rx_div_q, rx_cnt_q, tx_div_q, tx_cnt_q, div_sel;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_sh_q, rx_byte_q, tx_data;
  logic tx_busy_q, tx_q, tx_ready, tx_go;
  logic [8:0] tx_sh_q;
  logic [3:0] tx_bit_q;
  logic [AW-1:0] n_q, nn_q, cnt_q, i_q, j_q, k_q, n_m1;
  logic [19:0] acc_q, mac;
  logic [1:0] s_q;
  logic last_q, size_ok, cnt_last, k_last, j_last, i_last;
  logic [7:0] a_mem [2**AW];
  logic [7:0] b_mem [2**AW];
  logic [19:0] c_mem [2**AW];
  always_comb begin
    div_sel = b_sel[1] ? (b_sel[0] ? D3 : D2) : (b_sel[0] ? D1 : D0);
    n_m1 = n_q - AW'(1);
    k_last = k_q == n_m1;
    j_last = j_q == n_m1;
    i_last = i_q == n_m1;
    cnt_last = cnt_q == nn_q - AW'(1);
    size_ok = rx_vld_q && rx_byte_q != 8'd0 && rx_byte_q <= MAX_B;
    mac = acc_q + 20'(a_mem[i_q * n_q + k_q]) * 20'(b_mem[k_q * n_q + j_q]);
    tx_data = s_q == 2'd0 ? {4'h0, c_mem[cnt_q][19:16]} : s_q == 2'd1 ? c_mem[cnt_q][15:8] : c_mem[cnt_q][7:0];
    tx_ready = !tx_busy_q || (tx_cnt_q == '0 && tx_bit_q == 4'd9);
    tx_go = st_q == SEND && !last_q && tx_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st_q <= RX_IDLE;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_s3_q <= 1'b1;
      rx_div_q <= '0;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_byte_q <= '0;
      rx_vld_q <= 1'b0;
    end else begin
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      rx_vld_q <= 1'b0;
      if (rx_st_q != RX_IDLE && rx_cnt_q != '0) rx_cnt_q <= rx_cnt_q - DW'(1);
      else case (rx_st_q)
        RX_IDLE: if (rx_s3_q && !rx_s2_q) begin
          rx_st_q <= RX_START;
          rx_div_q <= div_sel;
          rx_cnt_q <= (div_sel >> 1) - DW'(1);
        end
        RX_START: begin
          rx_st_q <= rx_s2_q ? RX_IDLE : RX_DATA;
          rx_cnt_q <= rx_div_q - DW'(1);
          rx_bit_q <= '0;
        end
        RX_DATA: begin
          rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
          rx_cnt_q <= rx_div_q - DW'(1);
          rx_bit_q <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_q <= RX_STOP;
        end
        default: begin
          rx_st_q <= RX_IDLE;
          rx_vld_q <= rx_s2_q;
          rx_byte_q <= rx_sh_q;
        end
      endcase
    end
  end
  // a new frame may be loaded in the last clock of the previous stop bit, keeping frames gapless
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q <= 1'b0;
      tx_q <= 1'b1;
      tx_sh_q <= '0;
      tx_div_q <= '0;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
    end else if (tx_go) begin
      tx_busy_q <= 1'b1;
      tx_q <= 1'b0;
      tx_sh_q <= {1'b1, tx_data};
      tx_div_q <= div_sel;
      tx_cnt_q <= div_sel - DW'(1);
      tx_bit_q <= '0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q != '0) tx_cnt_q <= tx_cnt_q - DW'(1);
      else if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
      else begin
        tx_q <= tx_sh_q[0];
        tx_sh_q <= {1'b1, tx_sh_q[8:1]};
        tx_bit_q <= tx_bit_q + 4'd1;
        tx_cnt_q <= tx_div_q - DW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      n_q <= '0;
      nn_q <= '0;
      cnt_q <= '0;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
      acc_q <= '0;
      s_q <= '0;
      last_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (size_ok) begin
          n_q <= AW'(rx_byte_q);
          nn_q <= AW'(rx_byte_q) * AW'(rx_byte_q);
          cnt_q <= '0;
          st_q <= GET_A;
        end
        GET_A, GET_B: if (rx_vld_q) begin
          cnt_q <= cnt_last ? '0 : cnt_q + AW'(1);
          if (cnt_last) st_q <= st_q == GET_A ? GET_B : COMPUTE;
        end
        COMPUTE: begin
          k_q <= k_last ? '0 : k_q + AW'(1);
          acc_q <= k_last ? '0 : mac;
          if (k_last) j_q <= j_last ? '0 : j_q + AW'(1);
          if (k_last && j_last) i_q <= i_last ? '0 : i_q + AW'(1);
          if (k_last && j_last && i_last) begin
            st_q <= SEND;
            cnt_q <= '0;
            s_q <= '0;
            last_q <= 1'b0;
          end
        end
        default: begin
          if (tx_go) s_q <= s_q == 2'd2 ? 2'd0 : s_q + 2'd1;
          if (tx_go && s_q == 2'd2) begin
            cnt_q <= cnt_q + AW'(1);
            last_q <= cnt_last;
          end
          if (last_q && !tx_busy_q) st_q <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (st_q == GET_A && rx_vld_q) a_mem[cnt_q] <= rx_byte_q;
    if (st_q == GET_B && rx_vld_q) b_mem[cnt_q] <= rx_byte_q;
    if (st_q == COMPUTE && k_last) c_mem[i_q * n_q + j_q] <= mac;
  end
  assign tx = tx_q;
endmodule

// File: tb/tb_top.sv
// tb_top: drives UART matrix transactions into top and checks the TX stream against a matrix-product model.
module tb_top;
  localparam int CLK_FREQ = 576_000;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [1:0] b_sel = 2'b01;
  logic tx;
  int checks = 0, passes = 0, cyc = 0, mon_busy = 0;
  int bauds[4] = '{4800, 9600, 57600, 115200};
  int ma[100], mb[100];
  logic [7:0] exp_q[$], got_q[$];

  top #(.CLK_FREQ(CLK_FREQ), .MAX_N(10)) dut (.clk(clk), .rst(rst), .rx(rx), .b_sel(b_sel), .tx(tx));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bit_div(input logic [1:0] s);
    return CLK_FREQ / bauds[s];
  endfunction

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic stop);
    int d;
    logic [9:0] f;
    d = bit_div(b_sel);
    f = {stop, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (d) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic load_model(input int n);
    int s;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += ma[i*n+k] * mb[k*n+j];
        exp_q.push_back(8'(s >> 16));
        exp_q.push_back(8'(s >> 8));
        exp_q.push_back(8'(s));
      end
  endtask

  task automatic wait_drain(input int n);
    int d, lim;
    d = bit_div(b_sel);
    lim = n*n*n + n*n + 30*n*n*d + 50*d + 200;
    for (int t = 0; t < lim && (exp_q.size() != 0 || mon_busy != 0); t++) @(posedge clk);
    check("response_complete", exp_q.size(), 0);
    exp_q.delete();
    repeat (20*d) @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int n);
    got_q.delete();
    load_model(n);
    send_byte(8'(n), 1'b1);
    for (int i = 0; i < n*n; i++) send_byte(8'(ma[i]), 1'b1);
    for (int i = 0; i < n*n; i++) send_byte(8'(mb[i]), 1'b1);
    wait_drain(n);
  endtask

  task automatic check_lit(input string nm, input logic [7:0] lit[$]);
    check({nm, "_len"}, got_q.size(), lit.size());
    for (int i = 0; i < lit.size() && i < got_q.size(); i++) check(nm, got_q[i], lit[i]);
  endtask

  // TX monitor and compare process: decodes every frame from per-cycle samples
  initial begin : monitor
    logic prev;
    logic s [0:1299];
    logic [7:0] b;
    int d, lz, last_start, stop_i;
    prev = 1'b1;
    last_start = -1000000;
    forever begin
      @(negedge clk);
      if (prev && !tx && !rst) begin
        mon_busy = 1;
        d = bit_div(b_sel);
        stop_i = 9*d + d/2;
        if (cyc - last_start < 20*d) check("tx_frame_spacing", cyc - last_start, 10*d);
        last_start = cyc;
        s[0] = tx;
        for (int i = 1; i <= stop_i; i++) begin
          @(negedge clk);
          s[i] = tx;
        end
        lz = 0;
        while (lz < stop_i && !s[lz]) lz++;
        for (int m = 0; m < 8; m++) b[m] = s[(m+1)*d + d/2];
        check("tx_stop_bit", s[stop_i], 1);
        if (b[0]) check("tx_bit_period", lz, d);
        got_q.push_back(b);
        if (exp_q.size() == 0) check("tx_unexpected_byte", b, 256);
        else check("tx_byte", b, exp_q.pop_front());
        prev = s[stop_i];
        mon_busy = 0;
      end else prev = tx;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] lq[$];
    int low, n, d;
    repeat (5) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_tx", tx, 1);

    b_sel = 2'b01;
    for (int i = 0; i < 4; i++) begin ma[i] = i + 1; mb[i] = i + 5; end
    run_txn(2);
    lq = '{8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h16, 8'h00, 8'h00, 8'h2B, 8'h00, 8'h00, 8'h32};
    check_lit("t1_2x2", lq);

    b_sel = 2'b11;
    for (int i = 0; i < 100; i++) begin ma[i] = 255; mb[i] = 255; end
    run_txn(10);
    check("t2_count", got_q.size(), 300);
    check("t2_first", {got_q[0], got_q[1], got_q[2]}, 24'h09EC0A);
    check("t2_last", {got_q[297], got_q[298], got_q[299]}, 24'h09EC0A);

    got_q.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'h0B, 1'b1);
    ma[0] = 5; mb[0] = 7;
    run_txn(1);
    lq = '{8'h00, 8'h00, 8'h23};
    check_lit("t3_bad_sizes", lq);

    ma[0] = 255; mb[0] = 2;
    run_txn(1);
    lq = '{8'h00, 8'h01, 8'hFE};
    check_lit("t4_fast", lq);

    got_q.delete();
    d = bit_div(b_sel);
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    low = 0;
    for (int t = 0; t < 30*d; t++) begin
      @(negedge clk);
      if (!tx) low++;
    end
    check("rst_tx_high", low, 0);
    check("rst_no_output", got_q.size(), 0);
    @(posedge clk);
    #1;
    ma[0] = 3; mb[0] = 4;
    run_txn(1);
    lq = '{8'h00, 8'h00, 8'h0C};
    check_lit("t5_after_reset", lq);

    send_byte(8'h01, 1'b0);
    repeat (2*d) @(posedge clk);
    #1;
    ma[0] = 6; mb[0] = 7;
    run_txn(1);
    lq = '{8'h00, 8'h00, 8'h2A};
    check_lit("t6_framing", lq);

    b_sel = 2'b01;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2*bit_div(b_sel)) @(posedge clk);
    #1;
    b_sel = 2'b11;
    ma[0] = 9; mb[0] = 9;
    run_txn(1);
    lq = '{8'h00, 8'h00, 8'h51};
    check_lit("t7_glitch", lq);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 3);
      b_sel = 2'($urandom_range(2, 3));
      for (int i = 0; i < n*n; i++) begin
        ma[i] = $urandom_range(0, 255);
        mb[i] = $urandom_range(0, 255);
      end
      run_txn(n);
      check("rand_count", got_q.size(), 3*n*n);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/top.md
Name: top

Overview:
- Top-level UART matrix-multiply engine.
- Receives a square size N over a UART RX line, then N×N unsigned 8-bit elements of matrix A, then N×N elements of matrix B, all row-major.
- Computes C = A×B with a sequential multiply-accumulate datapath.
- Streams C back over the UART TX line. Baud rate is selected at runtime by b_sel.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz; used to derive baud divisors.
- MAX_N, 10, largest accepted matrix dimension.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  UART receive line, idle high, 8N1 format, LSB first.
- b_sel  input  2  baud select: 00=4800, 01=9600, 10=57600, 11=115200.
- tx  output  1  UART transmit line, idle high, 8N1 format, LSB first.

Behaviour:
- Reset: tx=1; FSM goes to IDLE; all counters, the UART shift registers and the accumulator clear to 0. Matrix storage need not be cleared.
- Reset mid-operation aborts any receive, compute or transmit. On release, tx stays 1 and the block waits for a new size byte.
- Baud divisor: bit period = CLK_FREQ/baud, integer-truncated (9600 @ 50 MHz = 5208 clocks).
  - b_sel is sampled when each frame starts.
  - RX and TX both use the selected rate.
- RX path:
  - rx passes through a 2-FF synchronizer.
  - A falling edge in idle starts a frame. Re-check at half a bit period; if rx is high, treat it as a glitch and return to idle.
  - Sample 8 data bits at bit centres, then the stop bit.
  - Stop bit = 0: framing error, byte discarded.
  - Stop bit = 1: one-cycle byte-valid strobe with the byte.
- FSM states: IDLE, GET_A, GET_B, COMPUTE, SEND, then back to IDLE.
  - IDLE: the next valid byte is N. If 1≤N≤MAX_N, latch N and go to GET_A. Otherwise (0 or >MAX_N) ignore it and stay in IDLE.
  - GET_A: store N² bytes to A[i][j], row-major; after the N²-th byte go to GET_B.
  - GET_B: same for B; after the N²-th byte go to COMPUTE.
  - COMPUTE: one unsigned 8×8 multiply-accumulate per clock. C[i][j] = Σk A[i][k]·B[k][j], held in a 20-bit accumulator (max 10·255·255 = 650250). Each result is written to C storage after k = N−1. Total ≈ N³ + N² clocks.
  - SEND: for each C element, row-major, transmit 3 bytes, MSB first: bits 23:16, 15:8, 7:0 of the zero-extended 24-bit value. That is 3·N² bytes back-to-back with no idle gap beyond the stop bit. After the last stop bit, go to IDLE.
- Bytes received while in COMPUTE or SEND are ignored.
- TX frame: start bit 0, 8 data bits LSB first, stop bit 1, each held exactly one bit period.
- Arithmetic is unsigned throughout; there is no overflow within MAX_N.

Test Plan:
- b_sel=01, 50 MHz. Send 02, A=01 02 03 04, B=05 06 07 08 → TX bytes 00 00 13 00 00 16 00 00 2B 00 00 32.
- b_sel=01. Send 0A, then 200 bytes of FF → 300 TX bytes, every triple 09 EC 0A. Check a TX bit period of 5208 clocks.
- Send 00, then 0B, then 01 05 07 → C = 00 00 23.
  - 00 and 0B are ignored.
  - The 01 is accepted as N=1, with A=05 and B=07.
- b_sel=11 (434 clocks/bit), N=1, A=FF, B=02 → TX 00 01 FE at the 115200 bit period.
- Assert rst for 1 cycle midway through the A bytes → tx=1, no output. A fresh N=1, A=03, B=04 transaction then returns 00 00 0C.
- Send a frame with stop bit 0 as the size byte → it is discarded. The next valid N=1 transaction completes normally.
